adder_reg64: RTL and testbench

- Registered 64-bit two-operand adder with carry-in and status flags.
- Used in the pipeline datapath for PC increment and branch-target computation.
- Captures operands on a valid strobe and presents sum and flags one clock later.
- Datapath width is set by a parameter.

---
 rtl/adder_reg64.sv | 72 +++++++
 tb/tb_adder_reg64.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/adder_reg64.sv
// Registered two-operand adder with carry-in and status flags, built from
// carry-select segments. Sum and flags appear one clock after in_valid.
module adder_reg64 #(
    parameter int WIDTH = 64,
    parameter int SEG   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             out_valid
);

    localparam int NSEG = WIDTH / SEG;

    if ((WIDTH % SEG) != 0 || (WIDTH % 16) != 0 || WIDTH < 16) begin : g_bad_param
        $error("adder_reg64: WIDTH must be a multiple of 16 and of SEG");
    end

    logic [NSEG:0]    carry;
    logic [WIDTH-1:0] sum_c;
    logic             overflow_c;

    assign carry[0] = cin;

    // Each segment computes both candidate sums up front so only a mux sits
    // on the inter-segment carry path.
    for (genvar i = 0; i < NSEG; i++) begin : g_seg
        logic [SEG:0] s0;
        logic [SEG:0] s1;

        assign s0 = {1'b0, a[i*SEG +: SEG]} + {1'b0, b[i*SEG +: SEG]};
        assign s1 = {1'b0, a[i*SEG +: SEG]} + {1'b0, b[i*SEG +: SEG]} + {{SEG{1'b0}}, 1'b1};

        assign sum_c[i*SEG +: SEG] = carry[i] ? s1[SEG-1:0] : s0[SEG-1:0];
        assign carry[i+1]          = carry[i] ? s1[SEG]     : s0[SEG];
    end

    assign overflow_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out       <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            // Result and flags load together so they always describe one sum;
            // operands are ignored entirely when in_valid is low.
            if (in_valid) begin
                out      <= sum_c;
                cout     <= carry[NSEG];
                overflow <= overflow_c;
                zero     <= (sum_c == '0);
                negative <= sum_c[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_adder_reg64.sv
// Self-checking bench for adder_reg64: a reference model pushes expected
// results into a scoreboard queue and a monitor pops them as results appear.
module tb_adder_reg64;

    localparam int W = 64;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
        logic         neg;
    } exp_t;

    logic         clk;
    logic         reset;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         in_valid;
    logic [W-1:0] out;
    logic         cout;
    logic         overflow;
    logic         zero;
    logic         negative;
    logic         out_valid;

    exp_t sb[$];
    exp_t last_exp;
    int   n_vec;
    int   n_bad;

    adder_reg64 #(.WIDTH(W), .SEG(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .out       (out),
        .cout      (cout),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative),
        .out_valid (out_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] s;
        exp_t       e;
        s      = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        e.sum  = s[W-1:0];
        e.cout = s[W];
        e.ovf  = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
        e.zero = (s[W-1:0] == '0);
        e.neg  = s[W-1];
        return e;
    endfunction

    task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        @(negedge clk);
        a        = x;
        b        = y;
        cin      = c;
        in_valid = 1'b1;
        sb.push_back(model(x, y, c));
    endtask

    task automatic idle();
        @(negedge clk);
        a        = 'x;
        b        = 'x;
        cin      = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".out"},       out,       '0);
        check({tag, ".cout"},      W'(cout),      '0);
        check({tag, ".overflow"},  W'(overflow),  '0);
        check({tag, ".zero"},      W'(zero),      '0);
        check({tag, ".negative"},  W'(negative),  '0);
        check({tag, ".out_valid"}, W'(out_valid), '0);
    endtask

    // Monitor: sample in_valid at the edge, compare outputs 1 time unit later.
    logic mon_v;
    logic mon_r;
    always @(posedge clk) begin
        mon_v = in_valid;
        mon_r = reset;
        #1;
        if (!mon_r && !reset) begin
            check("out_valid", W'(out_valid), W'(mon_v));
            if (mon_v) begin
                if (sb.size() == 0) begin
                    check("scoreboard_underflow", W'(1), W'(0));
                end else begin
                    last_exp = sb.pop_front();
                end
            end
            check("out",      out,           last_exp.sum);
            check("cout",     W'(cout),      W'(last_exp.cout));
            check("overflow", W'(overflow),  W'(last_exp.ovf));
            check("zero",     W'(zero),      W'(last_exp.zero));
            check("negative", W'(negative),  W'(last_exp.neg));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec    = 0;
        n_bad    = 0;
        last_exp = '0;
        reset    = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        in_valid = 1'b0;

        // Asynchronous reset before the first clock edge.
        #1 reset = 1'b1;
        #1 check_all_zero("reset_async");
        @(negedge clk);
        reset = 1'b0;

        // Nominal, then an idle cycle that must hold out and drop out_valid.
        drive(64'h1234567890ABCDEF, 64'hFEDCBA0987654321, 1'b0);
        idle();
        idle();

        drive(64'h7FFFFFFFFFFFFFFF, 64'h1, 1'b0);
        idle();
        drive(64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1);
        drive(64'h8000000000000000, 64'h8000000000000000, 1'b0);
        drive(64'h000000000000FFFF, 64'h0, 1'b1);
        drive(64'h0000FFFFFFFFFFFF, 64'h0, 1'b1);
        idle();

        // Back-to-back stream.
        drive(64'h1, 64'h2, 1'b0);
        drive(64'h3, 64'h4, 1'b1);
        drive(64'hFFFF, 64'h1, 1'b0);
        idle();

        for (int i = 0; i < 24; i++) begin
            drive({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle();
        end

        // Reset mid-stream while a result is presented and another is pending.
        drive(64'h5, 64'h6, 1'b0);
        drive(64'h7, 64'h8, 1'b0);
        #2;
        check("pre_reset.out_valid", W'(out_valid), W'(1));
        reset = 1'b1;
        sb.delete();
        last_exp = '0;
        #1 check_all_zero("reset_mid");
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        idle();
        drive(64'd100, 64'd200, 1'b1);
        idle();

        for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", W'(sb.size()), W'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
